// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA pattern generator.
package vga_pkg;

  typedef enum logic [2:0] {
    PAT_SOLID   = 3'd0,
    PAT_BARS    = 3'd1,
    PAT_CHECKER = 3'd2,
    PAT_RAMP    = 3'd3,
    PAT_BOX     = 3'd4
  } pattern_e;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical counters with combinational sync, display-enable and frame-strobe decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  localparam int unsigned HTotal  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned VTotal  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = $clog2(HTotal),
  localparam int unsigned VW      = $clog2(VTotal)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          hsync_act_o,
  output logic          vsync_act_o,
  output logic          de_o,
  output logic          frame_o
);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == HW'(HTotal - 1)) begin
      h_d = '0;
      v_d = (v_q == VW'(VTotal - 1)) ? '0 : v_q + VW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o         = h_q;
  assign v_o         = v_q;
  assign hsync_act_o = (h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_act_o = (v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign de_o        = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
  assign frame_o     = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: mode latch, bouncing box, pattern mux and registered outputs.
// Optional white 1-pixel border around the active area when VGA_BORDER_EN is defined.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DefHActive,
  parameter int unsigned H_FP       = DefHFp,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BP       = DefHBp,
  parameter int unsigned V_ACTIVE   = DefVActive,
  parameter int unsigned V_FP       = DefVFp,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BP       = DefVBp,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned COLOR_BITS = 1,
  parameter int unsigned BOX_SIZE   = 32,
  localparam int unsigned HW        = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int unsigned VW        = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [2:0]            mode_i,
  output logic [COLOR_BITS-1:0] red_o,
  output logic [COLOR_BITS-1:0] green_o,
  output logic [COLOR_BITS-1:0] blue_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [HW-1:0]         hpos_o,
  output logic [VW-1:0]         vpos_o,
  output logic                  frame_o
);

  localparam logic [COLOR_BITS-1:0] ChanOn = {COLOR_BITS{1'b1}};
  localparam int unsigned           BarW   = H_ACTIVE / 8;
  localparam logic [HW-1:0]         XMax   = HW'(H_ACTIVE - BOX_SIZE);
  localparam logic [VW-1:0]         YMax   = VW'(V_ACTIVE - BOX_SIZE);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          hsync_act, vsync_act, de, frame;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .h_o         (h),
    .v_o         (v),
    .hsync_act_o (hsync_act),
    .vsync_act_o (vsync_act),
    .de_o        (de),
    .frame_o     (frame)
  );

  assign hpos_o  = h;
  assign vpos_o  = v;
  assign frame_o = frame;

  // The frame-start pixel already uses the newly selected mode and box position,
  // so every frame is drawn with one consistent pattern.
  logic [2:0]    mode_q, mode_cur;
  logic [HW-1:0] box_x_q, box_x_d, draw_x_q, draw_x;
  logic [VW-1:0] box_y_q, box_y_d, draw_y_q, draw_y;
  logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;

  assign mode_cur = frame ? mode_i : mode_q;
  assign draw_x   = frame ? box_x_q : draw_x_q;
  assign draw_y   = frame ? box_y_q : draw_y_q;

  // Bounce: reverse before stepping outside [0, ACTIVE-BOX_SIZE].
  always_comb begin
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (frame) begin
      if (dir_x_q ? (box_x_q == XMax) : (box_x_q == '0)) dir_x_d = ~dir_x_q;
      box_x_d = (dir_x_d) ? box_x_q + HW'(1) : box_x_q - HW'(1);
      if (dir_y_q ? (box_y_q == YMax) : (box_y_q == '0)) dir_y_d = ~dir_y_q;
      box_y_d = (dir_y_d) ? box_y_q + VW'(1) : box_y_q - VW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q   <= 3'd0;
      box_x_q  <= '0;
      box_y_q  <= '0;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      draw_x_q <= '0;
      draw_y_q <= '0;
    end else begin
      mode_q   <= mode_cur;
      box_x_q  <= box_x_d;
      box_y_q  <= box_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      draw_x_q <= draw_x;
      draw_y_q <= draw_y;
    end
  end

  logic [31:0]           hx, vx;
  logic [2:0]            bar_idx;
  logic                  in_box;
  logic [COLOR_BITS-1:0] ramp, pix_r, pix_g, pix_b;

  assign hx = 32'(h);
  assign vx = 32'(v);

  always_comb begin
    bar_idx = 3'd7;
    if (hx < 8 * BarW) bar_idx = 3'(hx / BarW);
    in_box = (hx >= 32'(draw_x)) && (hx < 32'(draw_x) + BOX_SIZE) &&
             (vx >= 32'(draw_y)) && (vx < 32'(draw_y) + BOX_SIZE);
    ramp   = hx[COLOR_BITS+1:2];
    pix_r  = '0;
    pix_g  = '0;
    pix_b  = '0;
    case (pattern_e'(mode_cur))
      PAT_BARS: begin
        pix_r = {COLOR_BITS{~bar_idx[2]}};
        pix_g = {COLOR_BITS{~bar_idx[1]}};
        pix_b = {COLOR_BITS{~bar_idx[0]}};
      end
      PAT_CHECKER: begin
        if (hx[3] ^ vx[3]) begin
          pix_r = ChanOn;
          pix_g = ChanOn;
          pix_b = ChanOn;
        end
      end
      PAT_RAMP: begin
        pix_r = ramp;
        pix_g = ramp;
        pix_b = ramp;
      end
      PAT_BOX: begin
        pix_b = ChanOn;
        if (in_box) begin
          pix_r = ChanOn;
          pix_g = ChanOn;
        end
      end
      default: pix_r = ChanOn;
    endcase
`ifdef VGA_BORDER_EN
    if (hx == 0 || hx == H_ACTIVE - 1 || vx == 0 || vx == V_ACTIVE - 1) begin
      pix_r = ChanOn;
      pix_g = ChanOn;
      pix_b = ChanOn;
    end
`endif
    if (!de) begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
      hsync_o <= ~SYNC_POL;
      vsync_o <= ~SYNC_POL;
      de_o    <= 1'b0;
    end else begin
      red_o   <= pix_r;
      green_o <= pix_g;
      blue_o  <= pix_b;
      hsync_o <= hsync_act ? SYNC_POL : ~SYNC_POL;
      vsync_o <= vsync_act ? SYNC_POL : ~SYNC_POL;
      de_o    <= de;
    end
  end

endmodule
